// File: rtl/hpdcache_pkg.sv
// Shared types for the HPDcache refill path: refill FSM encoding and the
// MSHR metadata snapshot taken when an entry is acknowledged.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_TID_W      = 6;
  localparam int unsigned HPDCACHE_SID_W      = 3;
  localparam int unsigned HPDCACHE_SET_W      = 7;
  localparam int unsigned HPDCACHE_WAY_W      = 2;
  localparam int unsigned HPDCACHE_TAG_W      = 20;
  localparam int unsigned HPDCACHE_WORD_IDX_W = 3;

  typedef enum logic [2:0] {
    REFILL_IDLE  = 3'd0,
    REFILL_RECV  = 3'd1,
    REFILL_ARB   = 3'd2,
    REFILL_META  = 3'd3,
    REFILL_WRITE = 3'd4,
    REFILL_RSP   = 3'd5
  } hpdcache_refill_fsm_e;

  typedef struct packed {
    logic [HPDCACHE_TID_W-1:0]      req_id;
    logic [HPDCACHE_SID_W-1:0]      src_id;
    logic [HPDCACHE_SET_W-1:0]      set;
    logic [HPDCACHE_WAY_W-1:0]      way;
    logic [HPDCACHE_TAG_W-1:0]      tag;
    logic [HPDCACHE_WORD_IDX_W-1:0] word;
    logic                           need_rsp;
    logic                           wback;
    logic                           error;
  } hpdcache_refill_meta_t;

endpackage

// File: rtl/hpdcache_refill_linebuf.sv
// Flit-indexed line assembly buffer. Tracks the flit count and flags flits
// that break the expected line framing (early last, overflow).
module hpdcache_refill_linebuf
  import hpdcache_pkg::*;
#(
  parameter int unsigned FlitW = 128,
  parameter int unsigned LineW = 512
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic             clr_i,
  input  logic             last_i,
  input  logic [FlitW-1:0] data_i,
  output logic [LineW-1:0] line_o,
  output logic             flit_err_o
);

  localparam int unsigned Flits = LineW / FlitW;
  localparam int unsigned CntW  = $clog2(Flits) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Flits - 1);
  localparam logic [CntW-1:0] Full    = CntW'(Flits);

  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [Flits-1:0][FlitW-1:0] line_q, line_d;

  assign line_o = line_q;

  // Next count/buffer; a saturated count discards further flits.
  always_comb begin
    cnt_d      = cnt_q;
    line_d     = line_q;
    flit_err_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i) begin
      flit_err_o = last_i ? (cnt_q != LastIdx) : (cnt_q >= LastIdx);
      if (cnt_q != Full) begin
        for (int k = 0; k < Flits; k++) begin
          if (cnt_q == CntW'(k)) begin
            line_d[k] = data_i;
          end else begin
            line_d[k] = line_q[k];
          end
        end
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Buffer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/hpdcache_refill_ctrl.sv
// Refill controller: assembles memory response flits into a line, acks the
// MSHR entry, writes the line into the cache and answers the core.
module hpdcache_refill_ctrl
  import hpdcache_pkg::*;
#(
  parameter int unsigned MshrSets = 4,
  parameter int unsigned MshrWays = 2,
  parameter int unsigned SetW     = 7,
  parameter int unsigned TagW     = 20,
  parameter int unsigned WayW     = 2,
  parameter int unsigned WordW    = 64,
  parameter int unsigned FlitW    = 128,
  parameter int unsigned LineW    = 512,
  parameter int unsigned TidW     = 6,
  parameter int unsigned SidW     = 3,
  localparam int unsigned MshrSetW = (MshrSets > 1) ? $clog2(MshrSets) : 1,
  localparam int unsigned MshrWayW = (MshrWays > 1) ? $clog2(MshrWays) : 1,
  localparam int unsigned WordIdxW = $clog2(LineW / WordW)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         mem_rsp_valid_i,
  output logic                         mem_rsp_ready_o,
  input  logic [MshrWayW+MshrSetW-1:0] mem_rsp_id_i,
  input  logic [FlitW-1:0]             mem_rsp_data_i,
  input  logic                         mem_rsp_last_i,
  input  logic                         mem_rsp_error_i,
  output logic                         refill_req_o,
  input  logic                         refill_gnt_i,
  output logic                         mshr_ack_o,
  output logic                         mshr_ack_cs_o,
  output logic [MshrSetW-1:0]          mshr_ack_set_o,
  output logic [MshrWayW-1:0]          mshr_ack_way_o,
  input  logic [TidW-1:0]              mshr_req_id_i,
  input  logic [SidW-1:0]              mshr_src_id_i,
  input  logic [SetW-1:0]              mshr_set_i,
  input  logic [WayW-1:0]              mshr_way_i,
  input  logic [TagW-1:0]              mshr_tag_i,
  input  logic [WordIdxW-1:0]          mshr_word_i,
  input  logic                         mshr_need_rsp_i,
  input  logic                         mshr_wback_i,
  output logic                         refill_valid_o,
  input  logic                         refill_ready_i,
  output logic [SetW-1:0]              refill_set_o,
  output logic [WayW-1:0]              refill_way_o,
  output logic [TagW-1:0]              refill_tag_o,
  output logic [LineW-1:0]             refill_data_o,
  output logic                         refill_wback_o,
  output logic                         core_rsp_valid_o,
  input  logic                         core_rsp_ready_i,
  output logic [WordW-1:0]             core_rsp_data_o,
  output logic [TidW-1:0]              core_rsp_tid_o,
  output logic [SidW-1:0]              core_rsp_sid_o,
  output logic                         core_rsp_error_o
);

  localparam int unsigned FlitsPerLine = LineW / FlitW;

  // The metadata struct is sized by the package, so the parameters must agree with it.
  if (TidW != HPDCACHE_TID_W || SidW != HPDCACHE_SID_W || SetW != HPDCACHE_SET_W ||
      WayW != HPDCACHE_WAY_W || TagW != HPDCACHE_TAG_W || WordIdxW != HPDCACHE_WORD_IDX_W ||
      FlitsPerLine < 1 || (FlitsPerLine & (FlitsPerLine - 1)) != 0) begin : g_param_chk
    $error("hpdcache_refill_ctrl: unsupported parameter set");
  end

  hpdcache_refill_fsm_e           state_q, state_d;
  logic [MshrWayW+MshrSetW-1:0]   id_q, id_d;
  logic                           err_q, err_d;
  hpdcache_refill_meta_t          meta_q, meta_d;
  logic                           flit_acc_s, flit_err_s, clr_s;
  logic [LineW-1:0]               line_s;
  logic [LineW/WordW-1:0][WordW-1:0] words_s;

  assign flit_acc_s = mem_rsp_valid_i & mem_rsp_ready_o;
  assign words_s    = line_s;

  hpdcache_refill_linebuf #(
    .FlitW (FlitW),
    .LineW (LineW)
  ) i_linebuf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_i       (flit_acc_s),
    .clr_i      (clr_s),
    .last_i     (mem_rsp_last_i),
    .data_i     (mem_rsp_data_i),
    .line_o     (line_s),
    .flit_err_o (flit_err_s)
  );

  assign mem_rsp_ready_o  = (state_q == REFILL_IDLE) | (state_q == REFILL_RECV);
  assign refill_req_o     = (state_q == REFILL_ARB);
  assign mshr_ack_o       = (state_q == REFILL_ARB) & refill_gnt_i;
  assign mshr_ack_cs_o    = mshr_ack_o;
  assign mshr_ack_set_o   = id_q[MshrSetW-1:0];
  assign mshr_ack_way_o   = id_q[MshrSetW +: MshrWayW];
  assign refill_valid_o   = (state_q == REFILL_WRITE);
  assign refill_set_o     = meta_q.set;
  assign refill_way_o     = meta_q.way;
  assign refill_tag_o     = meta_q.tag;
  assign refill_wback_o   = meta_q.wback;
  assign refill_data_o    = line_s;
  assign core_rsp_valid_o = (state_q == REFILL_RSP);
  assign core_rsp_data_o  = words_s[meta_q.word];
  assign core_rsp_tid_o   = meta_q.req_id;
  assign core_rsp_sid_o   = meta_q.src_id;
  assign core_rsp_error_o = meta_q.error;

  // Next-state logic; flit count is cleared once the MSHR metadata is in hand.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_d   = err_q;
    meta_d  = meta_q;
    clr_s   = 1'b0;
    case (state_q)
      REFILL_IDLE: begin
        if (mem_rsp_valid_i) begin
          id_d    = mem_rsp_id_i;
          err_d   = mem_rsp_error_i | flit_err_s;
          state_d = mem_rsp_last_i ? REFILL_ARB : REFILL_RECV;
        end else begin
          state_d = REFILL_IDLE;
        end
      end
      REFILL_RECV: begin
        if (mem_rsp_valid_i) begin
          err_d   = err_q | mem_rsp_error_i | flit_err_s;
          state_d = mem_rsp_last_i ? REFILL_ARB : REFILL_RECV;
        end else begin
          state_d = REFILL_RECV;
        end
      end
      REFILL_ARB: begin
        state_d = refill_gnt_i ? REFILL_META : REFILL_ARB;
      end
      REFILL_META: begin
        meta_d.req_id   = mshr_req_id_i;
        meta_d.src_id   = mshr_src_id_i;
        meta_d.set      = mshr_set_i;
        meta_d.way      = mshr_way_i;
        meta_d.tag      = mshr_tag_i;
        meta_d.word     = mshr_word_i;
        meta_d.need_rsp = mshr_need_rsp_i;
        meta_d.wback    = mshr_wback_i;
        meta_d.error    = err_q;
        clr_s           = 1'b1;
        if (!err_q) begin
          state_d = REFILL_WRITE;
        end else if (mshr_need_rsp_i) begin
          state_d = REFILL_RSP;
        end else begin
          state_d = REFILL_IDLE;
        end
      end
      REFILL_WRITE: begin
        if (refill_ready_i) begin
          state_d = meta_q.need_rsp ? REFILL_RSP : REFILL_IDLE;
        end else begin
          state_d = REFILL_WRITE;
        end
      end
      REFILL_RSP: begin
        state_d = core_rsp_ready_i ? REFILL_IDLE : REFILL_RSP;
      end
      default: begin
        state_d = REFILL_IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REFILL_IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
      meta_q  <= meta_d;
    end
  end

endmodule

// File: tb/tb_hpdcache_refill_ctrl.sv
// Scoreboard bench for hpdcache_refill_ctrl: directed transactions push expected
// acks, refill writes and core responses; negedge monitors pop and compare.
module tb_hpdcache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         mem_rsp_valid_i, mem_rsp_ready_o;
  logic [2:0]   mem_rsp_id_i;
  logic [127:0] mem_rsp_data_i;
  logic         mem_rsp_last_i, mem_rsp_error_i;
  logic         refill_req_o, refill_gnt_i;
  logic         mshr_ack_o, mshr_ack_cs_o;
  logic [1:0]   mshr_ack_set_o;
  logic         mshr_ack_way_o;
  logic [5:0]   mshr_req_id_i;
  logic [2:0]   mshr_src_id_i;
  logic [6:0]   mshr_set_i;
  logic [1:0]   mshr_way_i;
  logic [19:0]  mshr_tag_i;
  logic [2:0]   mshr_word_i;
  logic         mshr_need_rsp_i, mshr_wback_i;
  logic         refill_valid_o, refill_ready_i;
  logic [6:0]   refill_set_o;
  logic [1:0]   refill_way_o;
  logic [19:0]  refill_tag_o;
  logic [511:0] refill_data_o;
  logic         refill_wback_o;
  logic         core_rsp_valid_o, core_rsp_ready_i;
  logic [63:0]  core_rsp_data_o;
  logic [5:0]   core_rsp_tid_o;
  logic [2:0]   core_rsp_sid_o;
  logic         core_rsp_error_o;

  hpdcache_refill_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_last_i(mem_rsp_last_i), .mem_rsp_error_i(mem_rsp_error_i),
    .refill_req_o(refill_req_o), .refill_gnt_i(refill_gnt_i),
    .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
    .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
    .mshr_req_id_i(mshr_req_id_i), .mshr_src_id_i(mshr_src_id_i),
    .mshr_set_i(mshr_set_i), .mshr_way_i(mshr_way_i), .mshr_tag_i(mshr_tag_i),
    .mshr_word_i(mshr_word_i), .mshr_need_rsp_i(mshr_need_rsp_i), .mshr_wback_i(mshr_wback_i),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_set_o(refill_set_o), .refill_way_o(refill_way_o), .refill_tag_o(refill_tag_o),
    .refill_data_o(refill_data_o), .refill_wback_o(refill_wback_o),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
    .core_rsp_data_o(core_rsp_data_o), .core_rsp_tid_o(core_rsp_tid_o),
    .core_rsp_sid_o(core_rsp_sid_o), .core_rsp_error_o(core_rsp_error_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] set; logic way; int cyc; } ack_t;
  typedef struct { logic [6:0] set; logic [1:0] way; logic [19:0] tag; logic [511:0] data;
                   logic wb; logic need; int cyc; } ref_t;
  typedef struct { logic [63:0] data; logic chk_data; logic [5:0] tid; logic [2:0] sid;
                   logic err; int cyc; } rsp_t;

  ack_t ack_q[$];
  ref_t ref_q[$];
  rsp_t rsp_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0, n_ack_seen = 0, n_ack_exp = 0;
  logic ack_seen = 1'b0, post_chk = 1'b0, post_need = 1'b0;

  logic [5:0]  cfg_tid;
  logic [2:0]  cfg_sid;
  logic [6:0]  cfg_set;
  logic [1:0]  cfg_way;
  logic [19:0] cfg_tag;
  logic [2:0]  cfg_word;
  logic        cfg_need, cfg_wb;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] flit(input logic [7:0] s, input int k);
    return {s, 24'hC0FFEE, 32'(k), 32'hFACE_0000 | 32'(k), 24'h000000, s};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // MSHR model: entry contents valid only in the cycle after an ack, junk otherwise.
  always @(posedge clk) begin
    #1;
    mshr_req_id_i   = ack_seen ? cfg_tid  : ~cfg_tid;
    mshr_src_id_i   = ack_seen ? cfg_sid  : ~cfg_sid;
    mshr_set_i      = ack_seen ? cfg_set  : ~cfg_set;
    mshr_way_i      = ack_seen ? cfg_way  : ~cfg_way;
    mshr_tag_i      = ack_seen ? cfg_tag  : ~cfg_tag;
    mshr_word_i     = ack_seen ? cfg_word : ~cfg_word;
    mshr_need_rsp_i = ack_seen ? cfg_need : ~cfg_need;
    mshr_wback_i    = ack_seen ? cfg_wb   : ~cfg_wb;
  end

  // Monitor: pops the scoreboard whenever the DUT presents an ack, refill or response.
  always @(negedge clk) begin
    ack_t a; ref_t r; rsp_t p;
    ack_seen = rst_ni & mshr_ack_o;
    if (rst_ni) begin
      if (post_chk) begin
        check("post_refill_rsp_valid", core_rsp_valid_o, post_need);
        check("post_refill_idle", mem_rsp_ready_o, !post_need);
        post_chk = 1'b0;
      end
      if (mshr_ack_o) begin
        n_ack_seen++;
        check("ack_expected", ack_q.size() != 0, 1'b1);
        check("ack_cs", mshr_ack_cs_o, 1'b1);
        if (ack_q.size() != 0) begin
          a = ack_q.pop_front();
          check("ack_set", mshr_ack_set_o, a.set);
          check("ack_way", mshr_ack_way_o, a.way);
          check("ack_cycle", cyc, a.cyc);
        end
      end
      if (refill_valid_o && refill_ready_i) begin
        check("refill_expected", ref_q.size() != 0, 1'b1);
        if (ref_q.size() != 0) begin
          r = ref_q.pop_front();
          check("refill_set", refill_set_o, r.set);
          check("refill_way", refill_way_o, r.way);
          check("refill_tag", refill_tag_o, r.tag);
          check("refill_wback", refill_wback_o, r.wb);
          check("refill_data", refill_data_o, r.data);
          check("refill_cycle", cyc, r.cyc);
          post_chk  = 1'b1;
          post_need = r.need;
        end
      end
      if (core_rsp_valid_o && core_rsp_ready_i) begin
        check("rsp_expected", rsp_q.size() != 0, 1'b1);
        if (rsp_q.size() != 0) begin
          p = rsp_q.pop_front();
          if (p.chk_data) check("rsp_data", core_rsp_data_o, p.data);
          check("rsp_tid", core_rsp_tid_o, p.tid);
          check("rsp_sid", core_rsp_sid_o, p.sid);
          check("rsp_error", core_rsp_error_o, p.err);
          check("rsp_cycle", cyc, p.cyc);
        end
      end
    end
  end

  task automatic send_flits(input logic [2:0] id, input int n, input int err_at,
                            input logic [7:0] seed, input logic with_last);
    for (int k = 0; k < n; k++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_id_i    = (k == 0) ? id : ~id;
      mem_rsp_data_i  = flit(seed, k);
      mem_rsp_last_i  = with_last && (k == n - 1);
      mem_rsp_error_i = (k == err_at);
      @(posedge clk); #1;
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    mem_rsp_error_i = 1'b0;
  endtask

  task automatic wait_done();
    logic done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #1;
      done = (ack_q.size() == 0) && (ref_q.size() == 0) && (rsp_q.size() == 0) && mem_rsp_ready_o;
    end
    check("txn_done", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic wy, input logic [1:0] st, input int n, input int err_at,
                         input logic [7:0] seed, input logic [5:0] tid, input logic [2:0] sid,
                         input logic [6:0] cset, input logic [1:0] cway, input logic [19:0] tag,
                         input logic [2:0] word, input logic need, input logic wb,
                         input int gd, input int rd);
    logic [511:0] line = '0;
    logic err;
    int c0 = cyc;
    ack_t a; ref_t r; rsp_t p;
    cfg_tid = tid; cfg_sid = sid; cfg_set = cset; cfg_way = cway;
    cfg_tag = tag; cfg_word = word; cfg_need = need; cfg_wb = wb;
    for (int k = 0; k < 4 && k < n; k++) line[k*128 +: 128] = flit(seed, k);
    err = (err_at >= 0) || (n != 4);
    a.set = st; a.way = wy; a.cyc = c0 + n + gd;
    ack_q.push_back(a);
    n_ack_exp++;
    if (!err) begin
      r.set = cset; r.way = cway; r.tag = tag; r.data = line; r.wb = wb; r.need = need;
      r.cyc = c0 + n + 2 + gd + rd;
      ref_q.push_back(r);
    end
    if (need) begin
      p.data = line[word*64 +: 64]; p.chk_data = !err; p.tid = tid; p.sid = sid; p.err = err;
      p.cyc = err ? (c0 + n + 2 + gd) : (c0 + n + 3 + gd + rd);
      rsp_q.push_back(p);
    end
    refill_gnt_i   = (gd == 0);
    refill_ready_i = (rd == 0);
    send_flits({wy, st}, n, err_at, seed, 1'b1);
    if (gd > 0 || rd > 0) begin
      for (int i = 0; i < gd; i++) begin
        @(negedge clk);
        check("stall_req_held", refill_req_o, 1'b1);
        check("stall_no_ack", mshr_ack_o, 1'b0);
        check("stall_flit_ready", mem_rsp_ready_o, 1'b0);
        @(posedge clk); #1;
      end
      refill_gnt_i = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < rd; i++) begin
        @(negedge clk);
        check("stall_refill_valid", refill_valid_o, 1'b1);
        check("stall_refill_data", refill_data_o, line);
        check("stall_refill_tag", refill_tag_o, tag);
        check("stall_flit_ready", mem_rsp_ready_o, 1'b0);
        @(posedge clk); #1;
      end
      refill_ready_i = 1'b1;
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rsp_id_i = 3'd0; mem_rsp_data_i = 128'd0;
    mem_rsp_last_i = 1'b0; mem_rsp_error_i = 1'b0;
    refill_gnt_i = 1'b1; refill_ready_i = 1'b1; core_rsp_ready_i = 1'b1;
    cfg_tid = 6'd0; cfg_sid = 3'd0; cfg_set = 7'd0; cfg_way = 2'd0;
    cfg_tag = 20'd0; cfg_word = 3'd0; cfg_need = 1'b0; cfg_wb = 1'b0;
    @(negedge clk);
    check("reset_flit_ready", mem_rsp_ready_o, 1'b1);
    check("reset_refill_req", refill_req_o, 1'b0);
    check("reset_ack", mshr_ack_o, 1'b0);
    check("reset_refill_valid", refill_valid_o, 1'b0);
    check("reset_rsp_valid", core_rsp_valid_o, 1'b0);
    check("reset_refill_data", refill_data_o, 512'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // clean line, slot {way=1,set=2}, word 5
    run_txn(1'b1, 2'd2, 4, -1, 8'h11, 6'h2A, 3'd5, 7'h45, 2'd3, 20'hABCDE, 3'd5, 1'b1, 1'b0, 0, 0);
    // prefetch
    run_txn(1'b0, 2'd1, 4, -1, 8'h22, 6'h01, 3'd1, 7'h12, 2'd1, 20'h12345, 3'd2, 1'b0, 1'b1, 0, 0);
    // bus error on flit 2
    run_txn(1'b1, 2'd3, 4, 2, 8'h33, 6'h15, 3'd2, 7'h7F, 2'd0, 20'hFFFFF, 3'd0, 1'b1, 1'b0, 0, 0);
    // early last on flit 1
    run_txn(1'b0, 2'd0, 2, -1, 8'h44, 6'h3F, 3'd7, 7'h00, 2'd2, 20'h00001, 3'd7, 1'b1, 1'b0, 0, 0);
    // overflow: six flits without last, then a last
    run_txn(1'b1, 2'd1, 7, -1, 8'h55, 6'h20, 3'd3, 7'h31, 2'd1, 20'h5A5A5, 3'd3, 1'b1, 1'b1, 0, 0);
    // error on a prefetch: ack only
    run_txn(1'b0, 2'd3, 4, 1, 8'h88, 6'h09, 3'd0, 7'h0A, 2'd0, 20'h00ABC, 3'd4, 1'b0, 1'b0, 0, 0);
    // grant withheld 10 cycles, refill ready withheld 3
    run_txn(1'b0, 2'd2, 4, -1, 8'h66, 6'h0C, 3'd4, 7'h2B, 2'd2, 20'hC3C3C, 3'd6, 1'b1, 1'b1, 10, 3);

    // reset in RECV after two flits
    send_flits(3'b101, 2, -1, 8'h99, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("midrst_flit_ready", mem_rsp_ready_o, 1'b1);
    check("midrst_refill_req", refill_req_o, 1'b0);
    check("midrst_ack", mshr_ack_o, 1'b0);
    check("midrst_refill_data", refill_data_o, 512'd0);
    check("midrst_rsp_data", core_rsp_data_o, 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 2'd0, 4, -1, 8'h77, 6'h33, 3'd6, 7'h5D, 2'd3, 20'h0F0F0, 3'd1, 1'b1, 1'b0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    check("ack_count", n_ack_seen, n_ack_exp);
    check("ack_q_empty", ack_q.size(), 0);
    check("refill_q_empty", ref_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
